// File: rtl/stream_decrypt_hash_pkg.sv
// Shared types and helpers for the streaming decrypt/hash block.
// Rotations are width-generic so one helper serves every word size.
package sdh_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ROT_DEF = 3;
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DIGEST
    } sdh_state_t;

    // x must be zero above bit w-1; result is confined to w bits
    function automatic logic [MAX_W-1:0] rotr(
        input logic [MAX_W-1:0] x,
        input int w,
        input int n
    );
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << w) - MAX_W'(1);
        return ((x >> n) | (x << (w - n))) & mask;
    endfunction

    function automatic logic [MAX_W-1:0] rotl(
        input logic [MAX_W-1:0] x,
        input int w,
        input int n
    );
        return rotr(x, w, w - n);
    endfunction

endpackage

// File: rtl/stream_decrypt_hash_if.sv
// Ciphertext in, plaintext out and digest handshakes of the block.
// slave is the block side, master is the link/consumer side.
interface stream_decrypt_hash_if #(
    parameter int DATA_W = 8
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              dig_valid;
    logic              dig_ready;
    logic [DATA_W-1:0] dig_data;
    logic              dig_err;

    modport slave (
        input  s_valid, s_data, s_last, m_ready, dig_ready,
        output s_ready, m_valid, m_data, m_last,
        output dig_valid, dig_data, dig_err
    );

    modport master (
        output s_valid, s_data, s_last, m_ready, dig_ready,
        input  s_ready, m_valid, m_data, m_last,
        input  dig_valid, dig_data, dig_err
    );

endinterface

// File: rtl/stream_decrypt_hash_round.sv
// Per-word function: plaintext and next running hash from one
// ciphertext word, the current hash and the key.
module sdh_round
    import sdh_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROT = ROT_DEF
) (
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] h,
    input  logic [DATA_W-1:0] key,
    output logic [DATA_W-1:0] p,
    output logic [DATA_W-1:0] h_next
);

    assign p = DATA_W'(rotr(MAX_W'(c), DATA_W, ROT)) ^ key;

    // carry out of the add is dropped on purpose
    assign h_next = (DATA_W'(rotl(MAX_W'(h), DATA_W, 1)) ^ c) + key;

endmodule

// File: rtl/stream_decrypt_hash.sv
// Streaming decrypt with keyed running hash; one plaintext word per
// accept through a single output register, one digest per message.
module stream_decrypt_hash
    import sdh_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROT = ROT_DEF,
    parameter int MAX_LEN = 16,
    parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_load,
    stream_decrypt_hash_if.slave bus,
    output logic              busy
);

    sdh_state_t        state;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] h;
    logic [DATA_W-1:0] h_cur;
    logic [DATA_W-1:0] h_next;
    logic [DATA_W-1:0] p;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  count_nxt;
    logic              acc;
    logic              ovf;
    logic              pass;

    sdh_round #(
        .DATA_W(DATA_W),
        .ROT(ROT)
    ) u_round (
        .c(bus.s_data),
        .h(h_cur),
        .key(key),
        .p(p),
        .h_next(h_next)
    );

    // hash is seeded with the key on the first word of a message
    assign h_cur = (state == IDLE) ? key : h;
    assign pass = (state == IDLE) || (state == RUN);

    assign bus.s_ready = rst_n && ((state == DRAIN) ||
        (pass && (!bus.m_valid || bus.m_ready)));

    assign acc = bus.s_valid && bus.s_ready;
    assign count_nxt = (state == IDLE) ? LEN_W'(1)
                                       : count + LEN_W'(1);
    assign ovf = !bus.s_last && (count_nxt == LEN_W'(MAX_LEN));

    assign busy = (state != IDLE);
    assign bus.dig_data = h;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            key <= '0;
            h <= '0;
            count <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data <= '0;
            bus.m_last <= 1'b0;
            bus.dig_valid <= 1'b0;
            bus.dig_err <= 1'b0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
            if (acc && pass) begin
                bus.m_valid <= 1'b1;
                bus.m_data <= p;
                bus.m_last <= bus.s_last || ovf;
                h <= h_next;
                count <= count_nxt;
            end
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        if (bus.s_last) begin
                            state <= DIGEST;
                            bus.dig_valid <= 1'b1;
                        end else if (ovf) begin
                            state <= DRAIN;
                            bus.dig_err <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else if (key_load) begin
                        key <= key_in;
                    end
                end
                RUN: begin
                    if (acc && bus.s_last) begin
                        state <= DIGEST;
                        bus.dig_valid <= 1'b1;
                    end else if (acc && ovf) begin
                        state <= DRAIN;
                        bus.dig_err <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (acc && bus.s_last) begin
                        state <= DIGEST;
                        bus.dig_valid <= 1'b1;
                    end
                end
                DIGEST: begin
                    if (bus.dig_ready) begin
                        state <= IDLE;
                        bus.dig_valid <= 1'b0;
                        bus.dig_err <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_decrypt_hash.sv
// Directed bench for stream_decrypt_hash (DATA_W=8, ROT=3, MAX_LEN=4)
// with hand-computed plaintext words and digests.
module tb_stream_decrypt_hash;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       key_load = 1'b0;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [9:0] mq[$];
    logic [9:0] dq[$];

    stream_decrypt_hash_if #(.DATA_W(8)) bus ();

    stream_decrypt_hash #(
        .DATA_W(8),
        .ROT(3),
        .MAX_LEN(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .key_load(key_load),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // record completed handshakes half a cycle before the edge
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready)
            mq.push_back({1'b1, bus.m_last, bus.m_data});
        if (rst_n && bus.dig_valid && bus.dig_ready)
            dq.push_back({1'b1, bus.dig_err, bus.dig_data});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_in = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic l);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data = c;
        bus.s_last = l;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready;
        end
        if (!ok) chk("send_timeout", 32'(0), 32'(1));
        step();
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
    endtask

    task automatic settle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = !busy && !bus.m_valid;
        end
        if (!done) chk("settle_timeout", 32'(0), 32'(1));
        step();
    endtask

    task automatic exp_m(input string tag, input logic [7:0] d,
                         input logic l);
        logic [9:0] got;
        got = 10'h000;
        if (mq.size() > 0) got = mq.pop_front();
        chk(tag, 32'(got), 32'({1'b1, l, d}));
    endtask

    task automatic exp_d(input string tag, input logic [7:0] d,
                         input logic e);
        logic [9:0] got;
        got = 10'h000;
        if (dq.size() > 0) got = dq.pop_front();
        chk(tag, 32'(got), 32'({1'b1, e, d}));
    endtask

    task automatic exp_empty(input string tag);
        chk(tag, 32'(mq.size() + dq.size()), 32'(0));
    endtask

    task automatic run_t1(input string pfx);
        send(8'h6C, 1'b0);
        send(8'h9D, 1'b1);
        settle();
        exp_m({pfx, "_w0"}, 8'hD7, 1'b0);
        exp_m({pfx, "_w1"}, 8'hE9, 1'b1);
        exp_d({pfx, "_dig"}, 8'h53, 1'b0);
        exp_empty({pfx, "_empty"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.s_last = 1'b0;
        bus.m_ready = 1'b1;
        bus.dig_ready = 1'b1;

        step();
        step();
        @(negedge clk);
        chk("rst_flags", 32'({bus.s_ready, bus.m_valid, bus.m_last,
            bus.dig_valid, bus.dig_err, busy}), 32'(0));
        chk("rst_data", 32'({bus.m_data, bus.dig_data}), 32'(0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(bus.s_ready), 32'(1));
        step();

        // two-word message
        load_key(8'h5A);
        run_t1("t1");

        // single word, zero key
        load_key(8'h00);
        send(8'h01, 1'b1);
        chk("t2_dvalid", 32'({bus.dig_valid, bus.dig_err}), 32'(2));
        chk("t2_ddata", 32'(bus.dig_data), 32'(8'h01));
        chk("t2_mout", 32'({bus.m_valid, bus.m_last, bus.m_data}),
            32'({2'b11, 8'h20}));
        settle();
        exp_m("t2_w0", 8'h20, 1'b1);
        exp_d("t2_dig", 8'h01, 1'b0);
        exp_empty("t2_empty");

        // output backpressure
        load_key(8'h5A);
        bus.m_ready = 1'b0;
        send(8'h6C, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data = 8'h9D;
        bus.s_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_sready", 32'(bus.s_ready), 32'(0));
            chk("t3_hold", 32'({bus.m_valid, bus.m_last, bus.m_data}),
                32'({2'b10, 8'hD7}));
        end
        step();
        bus.m_ready = 1'b1;
        send(8'h9D, 1'b1);
        settle();
        exp_m("t3_w0", 8'hD7, 1'b0);
        exp_m("t3_w1", 8'hE9, 1'b1);
        exp_d("t3_dig", 8'h53, 1'b0);
        exp_empty("t3_empty");

        // overflow at four words
        send(8'h6C, 1'b0);
        send(8'h9D, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        chk("t4_drain", 32'({bus.s_ready, bus.dig_err, busy}), 32'(7));
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        settle();
        exp_m("t4_w0", 8'hD7, 1'b0);
        exp_m("t4_w1", 8'hE9, 1'b0);
        exp_m("t4_w2", 8'h5A, 1'b0);
        exp_m("t4_w3", 8'hA5, 1'b1);
        exp_d("t4_dig", 8'h59, 1'b1);
        exp_empty("t4_empty");

        // digest stall blocks the next message
        bus.dig_ready = 1'b0;
        send(8'h6C, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data = 8'h9D;
        bus.s_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t5_dvalid", 32'({bus.dig_valid, bus.dig_err}), 32'(2));
            chk("t5_ddata", 32'(bus.dig_data), 32'(8'h32));
            chk("t5_sready", 32'(bus.s_ready), 32'(0));
        end
        chk("t5_nodig", 32'(dq.size()), 32'(0));
        step();
        bus.dig_ready = 1'b1;
        send(8'h9D, 1'b1);
        settle();
        exp_m("t5_w0", 8'hD7, 1'b1);
        exp_m("t5_w1", 8'hE9, 1'b1);
        exp_d("t5_dig0", 8'h32, 1'b0);
        exp_d("t5_dig1", 8'h83, 1'b0);
        exp_empty("t5_empty");

        // reset mid-message
        send(8'h6C, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rst", 32'({busy, bus.m_valid, bus.dig_valid}), 32'(0));
        repeat (4) step();
        exp_empty("t6_nodig");
        load_key(8'h5A);
        run_t1("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_decrypt_hash.md
Name: stream_decrypt_hash

Overview:
Streaming successor to the 8-bit combinational decrypt/hash pair. Accepts a ciphertext message of up to MAX_LEN words over a valid/ready stream and emits the decrypted words one cycle later on an output stream. It folds every ciphertext word into a keyed running hash and presents one digest per message on a separate handshake. It sits between the link receiver and the message consumer; the key is loaded from a configuration register.

Parameters:
DATA_W, 8, word width of ciphertext, plaintext, key and digest
ROT, 3, right-rotate amount used in decryption (0 < ROT < DATA_W)
MAX_LEN, 16, maximum words per message before overflow
LEN_W, $clog2(MAX_LEN+1), width of the word counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
key_in  in  DATA_W  key value
key_load  in  1  load key_in into the key register (honoured in IDLE only)
s_valid  in  1  ciphertext word valid
s_ready  out  1  ciphertext word accepted when s_valid && s_ready
s_data  in  DATA_W  ciphertext word
s_last  in  1  final word of message
m_valid  out  1  plaintext word valid
m_ready  in  1  consumer ready
m_data  out  DATA_W  plaintext word
m_last  out  1  final plaintext word of message
dig_valid  out  1  digest valid
dig_ready  in  1  digest consumer ready
dig_data  out  DATA_W  message digest
dig_err  out  1  message overflowed MAX_LEN
busy  out  1  state != IDLE

Behaviour:
- Reset: one clock, synchronous, active-low. Any rising edge with rst_n=0 gives state=IDLE, key=0, hash=0, count=0, and all outputs 0 (s_ready=0 during reset).
- Decrypt per accepted word c: p = rotr(c, ROT) ^ key.
- Hash: h starts at key on the first word. Update h' = (rotl(h,1) ^ c) + key, modulo 2^DATA_W (carry dropped).
- FSM states: IDLE, RUN, DRAIN, DIGEST.
- IDLE: key_load updates key. s_ready = !m_valid || m_ready. The first accept loads h = key, applies the first update, sets count=1 and moves to RUN, or to DIGEST if s_last.
- RUN: key_load is ignored. s_ready = !m_valid || m_ready. Each accept updates h and count.
  - s_last → DIGEST.
  - count reaching MAX_LEN without s_last: that word goes out with m_last=1, dig_err is latched to 1, next state DRAIN.
- DRAIN: s_ready=1; words are discarded (no m_valid, no hash update). The word accepted with s_last moves to DIGEST.
- DIGEST: s_ready=0. dig_valid=1 with dig_data=h and dig_err held stable until dig_ready. Then → IDLE, with dig_err cleared and count=0.
- A digest that is already valid may be taken in the same cycle as the final m_valid word or before it. dig_valid rises on the cycle after the last accept.
- Latency: plaintext appears on m_data exactly 1 cycle after the accept. It is a single output register.
- m_data and m_last are held stable while m_valid && !m_ready. A new accept in the same cycle as m_ready replaces the word (full throughput, 1 word/cycle).
- A single-word message (s_last on the first word) is legal.
- key_load in the same cycle as an IDLE accept: the new key is ignored for that message; the old key is used.
- Reset mid-message: the message is abandoned and no digest is produced.

Decomposition:
- Package sdh_pkg: state enum sdh_state_t {IDLE,RUN,DRAIN,DIGEST}; functions rotl/rotr parametrised on DATA_W; default ROT.
- One sub-module, sdh_round: combinational (c, h, key) → (p, h_next). Keeping it separate lets the per-word function be unit-tested against the stream wrapper.

Test Plan:
1. DATA_W=8, ROT=3, key=0x5A. Message {6C, 9D(last)} with m_ready=1 → m_data D7 then E9, m_last on E9. Then dig_data=0x53, dig_err=0.
2. key=0x00, single word 0x01 (last) → m_data=0x20, m_last=1, dig_data=0x01, dig_valid on the cycle after the accept.
3. Backpressure: message from test 1 with m_ready=0 for 3 cycles after the first output → m_data holds D7, s_ready=0 until m_ready=1, and ordering is preserved.
4. Overflow, MAX_LEN=4: send 6 words, s_last on the 6th → exactly 4 plaintext words out, the 4th with m_last=1. Words 5–6 are accepted and dropped. dig_err=1, then IDLE.
5. Digest stall: hold dig_ready=0 for 5 cycles → dig_data and dig_valid stay stable, s_ready=0, and no new message starts until the handshake completes.
6. rst_n=0 for 1 cycle mid-message, then key_load 0x5A and rerun test 1 → no digest from the aborted message, and test 1 results are reproduced exactly.
